// File: rtl/dmem_arbiter_if.sv
// Request/response and data_mem bus bundle for dmem_arbiter.
// slave = arbiter view; master = requesters plus data_mem view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [3:0]        r0_sign_mask;
  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic [3:0]        r1_sign_mask;
  logic              r0_ack;
  logic              r1_ack;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [3:0]        mem_sign_mask;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_clk_stall;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_sign_mask,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_sign_mask,
    input  mem_read_data, mem_clk_stall,
    output r0_ack, r1_ack, rsp_rdata, rsp_err, busy,
    output mem_addr, mem_wdata, mem_memread, mem_memwrite, mem_sign_mask
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_sign_mask,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_sign_mask,
    output mem_read_data, mem_clk_stall,
    input  r0_ack, r1_ack, rsp_rdata, rsp_err, busy,
    input  mem_addr, mem_wdata, mem_memread, mem_memwrite, mem_sign_mask
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of data_mem: turns level req/ack
// handshakes into single-cycle memory strobes, waits out clk_stall with a timeout.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_STALL = 64
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_STALL) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_STALL - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              pick;

  // Lone requester wins outright; contention alternates away from the last winner.
  assign pick = (bus.r0_req && bus.r1_req) ? ~last_grant_q : bus.r1_req;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    stall_cnt_d  = stall_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    busy_d       = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          grant_d = pick;
          we_d    = pick ? bus.r1_we        : bus.r0_we;
          addr_d  = pick ? bus.r1_addr      : bus.r0_addr;
          wdata_d = pick ? bus.r1_wdata     : bus.r0_wdata;
          mask_d  = pick ? bus.r1_sign_mask : bus.r0_sign_mask;
          rd_d    = pick ? ~bus.r1_we       : ~bus.r0_we;
          wr_d    = pick ? bus.r1_we        : bus.r0_we;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        stall_cnt_d = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.mem_clk_stall) begin
          if (!we_q) rdata_d = bus.mem_read_data;
          err_d   = 1'b0;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = S_RESP;
        end else if (stall_cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = S_RESP;
        end else if (stall_cnt_q < CNT_LAST) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        last_grant_d = grant_q;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      stall_cnt_q  <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      stall_cnt_q  <= stall_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.r0_ack        = ack0_q;
  assign bus.r1_ack        = ack1_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_err       = err_q;
  assign bus.busy          = busy_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_memread   = rd_q;
  assign bus.mem_memwrite  = wr_q;
  assign bus.mem_sign_mask = mask_q;
endmodule
